// File: rtl/aes_pkg.sv
// Shared constants, state encoding and the ShiftRows byte permutation for
// the serial MixColumns datapath.
package aes_pkg;

    localparam int AES_STATE_W = 128;
    localparam int AES_NB      = 4;

    // Low byte of the AES field polynomial x^8 + x^4 + x^3 + x + 1 (0x11B)
    localparam logic [7:0] GF_REDUCE = 8'h1B;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } mc_state_e;

    typedef logic [31:0] column_t;

    // Byte k of the state lives at s[127-8k -: 8]; s[r][c] is byte 4c+r.
    // Row r is rotated left by r positions: s'[r][c] = s[r][(c+r) mod 4].
    function automatic logic [AES_STATE_W-1:0] shift_rows(input logic [AES_STATE_W-1:0] s);
        logic [AES_STATE_W-1:0] r;
        r = '0;
        for (int c = 0; c < AES_NB; c++) begin
            for (int row = 0; row < 4; row++) begin
                r[AES_STATE_W-1-8*(4*c+row) -: 8] =
                    s[AES_STATE_W-1-8*(4*((c+row)%AES_NB)+row) -: 8];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/mix_columns_serial_if.sv
// Upstream/downstream handshake bundle for the serial MixColumns block.
// The master side feeds states in and drains results; the slave is the block.
interface mix_columns_serial_if;
    import aes_pkg::*;

    logic [AES_STATE_W-1:0] ip;
    logic                   in_valid;
    logic                   in_ready;
    logic                   mix_en;
    logic [AES_STATE_W-1:0] op;
    logic                   out_valid;
    logic                   out_ready;

    modport master (
        output ip,
        output in_valid,
        output mix_en,
        output out_ready,
        input  in_ready,
        input  op,
        input  out_valid
    );

    modport slave (
        input  ip,
        input  in_valid,
        input  mix_en,
        input  out_ready,
        output in_ready,
        output op,
        output out_valid
    );

endinterface

// File: rtl/mix_column_unit.sv
// Combinational MixColumns for one 32-bit column over GF(2^8).
// Column byte 0 (row 0) is the most significant byte.
module mix_column_unit
    import aes_pkg::*;
(
    input  column_t col_i,
    output column_t col_o
);

    // Multiply by x in GF(2^8), folding the overflow bit back with 0x1B
    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? GF_REDUCE : 8'h00);
    endfunction

    logic [7:0] a0, a1, a2, a3;

    // Matrix rows {2,3,1,1} rotated; 3*a is written as xtime(a)^a
    always_comb begin
        a0 = col_i[31:24];
        a1 = col_i[23:16];
        a2 = col_i[15:8];
        a3 = col_i[7:0];
        col_o[31:24] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
        col_o[23:16] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
        col_o[15:8]  = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
        col_o[7:0]   = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
    end

endmodule

// File: rtl/mix_columns_serial.sv
// ShiftRows + MixColumns over one AES state, one column per clock.
// ShiftRows is applied at capture time; a single shared column unit then
// rewrites columns 0..3 in place before the result is offered downstream.
module mix_columns_serial
    import aes_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    mix_columns_serial_if.slave  bus
);

    mc_state_e              state_q, state_d;
    logic [1:0]             col_q, col_d;
    logic [AES_STATE_W-1:0] work_q, work_d;
    logic                   mix_en_q, mix_en_d;

    column_t cur_col;
    column_t mixed_col;
    column_t new_col;

    // Pick the column addressed by the counter out of the working register
    always_comb begin
        cur_col = work_q[127:96];
        case (col_q)
            2'd0: cur_col = work_q[127:96];
            2'd1: cur_col = work_q[95:64];
            2'd2: cur_col = work_q[63:32];
            2'd3: cur_col = work_q[31:0];
            default: cur_col = work_q[127:96];
        endcase
    end

    mix_column_unit u_mix_column_unit (
        .col_i (cur_col),
        .col_o (mixed_col)
    );

    // Final rounds skip MixColumns, so the column is written back untouched
    always_comb begin
        new_col = mix_en_q ? mixed_col : cur_col;
    end

    // Next-state logic: capture in IDLE, walk columns in CALC, hold in DONE
    always_comb begin
        state_d  = state_q;
        col_d    = col_q;
        work_d   = work_q;
        mix_en_d = mix_en_q;
        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    work_d   = shift_rows(bus.ip);
                    mix_en_d = bus.mix_en;
                    col_d    = 2'd0;
                    state_d  = CALC;
                end
            end
            CALC: begin
                case (col_q)
                    2'd0: work_d[127:96] = new_col;
                    2'd1: work_d[95:64]  = new_col;
                    2'd2: work_d[63:32]  = new_col;
                    2'd3: work_d[31:0]   = new_col;
                    default: work_d      = work_q;
                endcase
                col_d = col_q + 2'd1;
                if (col_q == 2'd3) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State registers; reset wins over any handshake in the same cycle
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            col_q    <= 2'd0;
            work_q   <= '0;
            mix_en_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            col_q    <= col_d;
            work_q   <= work_d;
            mix_en_q <= mix_en_d;
        end
    end

    // Handshake flags decode straight from the state; op is the working register
    always_comb begin
        bus.in_ready  = (state_q == IDLE);
        bus.out_valid = (state_q == DONE);
        bus.op        = work_q;
    end

endmodule

// File: tb/tb_mix_columns_serial.sv
// Bench for mix_columns_serial: a reference model built from GF(2^8)
// multiplication and byte-matrix indexing predicts every result, and a
// per-cycle monitor compares handshake flags and op against it.
module tb_mix_columns_serial;

    logic clk;
    logic rst_n;

    mix_columns_serial_if bus();

    mix_columns_serial dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks;
    int errors;
    int cyc;
    bit mon_en;
    bit busy;
    int acc_cyc;
    logic [127:0] exp_op;
    int acc_list[$];

    localparam logic [127:0] IP29  = 128'hd42711aee0bf98f1b8b45de51e415230;
    localparam logic [127:0] OP29  = 128'h046681e5e0cb199a48f8d37a2806264c;
    localparam logic [127:0] OP30  = 128'hd4bf5d30e0b452aeb84111f11e2798e5;
    localparam logic [127:0] ST31  = 128'hdb135345f20a225cc6c6c6c6d4d4d4d5;
    localparam logic [127:0] OP31  = 128'h8e4da1bc9fdc589dc6c6c6c6d5d5d7d6;

    // Schoolbook GF(2^8) product reduced by 0x11B
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [15:0] p;
        p = 16'h0;
        for (int i = 0; i < 8; i++)
            if (b[i]) p = p ^ ({8'h00, a} << i);
        for (int i = 15; i >= 8; i--)
            if (p[i]) p = p ^ (16'h011B << (i - 8));
        return p[7:0];
    endfunction

    function automatic logic [7:0] coef(input int idx);
        case (idx)
            0: return 8'h02;
            1: return 8'h03;
            default: return 8'h01;
        endcase
    endfunction

    function automatic logic [127:0] aes_model(input logic [127:0] d, input bit mix);
        logic [7:0] s[4][4];
        logic [7:0] t[4][4];
        logic [7:0] acc;
        logic [127:0] o;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                s[r][c] = d[127-8*(4*c+r) -: 8];
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                t[r][c] = s[r][(c+r)%4];
        o = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                if (mix) begin
                    acc = 8'h00;
                    for (int k = 0; k < 4; k++)
                        acc = acc ^ gmul(coef((k - r + 4) % 4), t[k][c]);
                end else begin
                    acc = t[r][c];
                end
                o[127-8*(4*c+r) -: 8] = acc;
            end
        end
        return o;
    endfunction

    function automatic logic [127:0] inv_shift(input logic [127:0] d);
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                o[127-8*(4*((c+r)%4)+r) -: 8] = d[127-8*(4*c+r) -: 8];
        return o;
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic checkOutput(input string name, input logic [127:0] actual, input logic [127:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input bit v, input logic [127:0] d, input bit m,
                                 input bit ordy, input bit rn);
        bus.in_valid  = v;
        bus.ip        = d;
        bus.mix_en    = m;
        bus.out_ready = ordy;
        rst_n         = rn;
    endtask

    // Negedge: compare DUT against the model, then predict the coming edge.
    // Acceptance at edge A => DONE visible from negedge A+5 until handshake.
    task automatic tick();
        bit exp_ov;
        @(negedge clk);
        if (mon_en) begin
            exp_ov = busy && (cyc >= acc_cyc + 5);
            checkOutput("mon_in_ready", {127'b0, bus.in_ready}, {127'b0, !busy});
            checkOutput("mon_out_valid", {127'b0, bus.out_valid}, {127'b0, exp_ov});
            if (exp_ov)
                checkOutput("mon_op", bus.op, exp_op);
            if (!rst_n) begin
                busy = 1'b0;
            end else if (!busy && bus.in_valid) begin
                busy    = 1'b1;
                acc_cyc = cyc;
                exp_op  = aes_model(bus.ip, bus.mix_en);
                acc_list.push_back(cyc);
            end else if (exp_ov && bus.out_ready) begin
                busy = 1'b0;
            end
        end
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic waitDone(output int lat);
        lat = 0;
        while (!bus.out_valid && lat < 20) begin
            tick();
            lat++;
        end
    endtask

    task automatic directedBlock(input string name, input logic [127:0] d, input bit m,
                                 input logic [127:0] lit);
        int lat;
        applyStimulus(1'b1, d, m, 1'b1, 1'b1);
        tick();
        applyStimulus(1'b0, rand128(), 1'b0, 1'b1, 1'b1);
        waitDone(lat);
        checkOutput({name, "_latency"}, 128'(lat), 128'd4);
        checkOutput(name, bus.op, lit);
        tick();
    endtask

    initial begin
        logic [127:0] held;
        int lat;
        checks  = 0;
        errors  = 0;
        cyc     = 0;
        busy    = 1'b0;
        acc_cyc = 0;
        exp_op  = '0;
        mon_en  = 1'b0;

        checkOutput("model_mix", aes_model(IP29, 1'b1), OP29);
        checkOutput("model_shift_only", aes_model(IP29, 1'b0), OP30);
        checkOutput("model_columns", aes_model(inv_shift(ST31), 1'b1), OP31);

        applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b0);
        tick();
        mon_en = 1'b1;
        tick();
        applyStimulus(1'b0, '0, 1'b0, 1'b1, 1'b1);
        checkOutput("reset_op", bus.op, 128'h0);
        checkOutput("reset_out_valid", {127'b0, bus.out_valid}, 128'h0);
        checkOutput("reset_in_ready", {127'b0, bus.in_ready}, 128'h1);

        directedBlock("vector_mix", IP29, 1'b1, OP29);
        directedBlock("vector_final", IP29, 1'b0, OP30);
        directedBlock("vector_columns", inv_shift(ST31), 1'b1, OP31);

        // Stalled output: new data offered while DONE must be ignored
        applyStimulus(1'b1, IP29, 1'b1, 1'b0, 1'b1);
        tick();
        applyStimulus(1'b0, rand128(), 1'b0, 1'b0, 1'b1);
        waitDone(lat);
        checkOutput("stall_latency", 128'(lat), 128'd4);
        held = bus.op;
        for (int i = 0; i < 10; i++) begin
            applyStimulus(i[0], rand128(), $urandom_range(0, 1) == 1, 1'b0, 1'b1);
            tick();
            checkOutput("stall_hold_op", bus.op, held);
            checkOutput("stall_in_ready", {127'b0, bus.in_ready}, 128'h0);
        end
        applyStimulus(1'b0, rand128(), 1'b0, 1'b1, 1'b1);
        checkOutput("stall_release_op", bus.op, OP29);
        tick();
        checkOutput("stall_back_idle", {127'b0, bus.in_ready}, 128'h1);

        // Reset during the second CALC cycle aborts the block
        applyStimulus(1'b1, rand128(), 1'b1, 1'b1, 1'b1);
        tick();
        applyStimulus(1'b0, rand128(), 1'b1, 1'b1, 1'b1);
        tick();
        applyStimulus(1'b0, rand128(), 1'b1, 1'b1, 1'b0);
        tick();
        applyStimulus(1'b0, rand128(), 1'b1, 1'b1, 1'b1);
        checkOutput("abort_in_ready", {127'b0, bus.in_ready}, 128'h1);
        checkOutput("abort_out_valid", {127'b0, bus.out_valid}, 128'h0);
        checkOutput("abort_op", bus.op, 128'h0);
        directedBlock("after_abort", IP29, 1'b0, OP30);

        // Back-to-back blocks at full throughput
        acc_list.delete();
        for (int i = 0; i < 32; i++) begin
            applyStimulus(1'b1, rand128(), $urandom_range(0, 1) == 1, 1'b1, 1'b1);
            tick();
        end
        applyStimulus(1'b0, rand128(), 1'b0, 1'b1, 1'b1);
        checkOutput("b2b_count_ok", {127'b0, acc_list.size() >= 5}, 128'h1);
        for (int i = 1; i < acc_list.size(); i++)
            checkOutput("b2b_spacing", 128'(acc_list[i] - acc_list[i-1]), 128'd6);
        for (int i = 0; i < 8; i++)
            tick();

        // Random traffic with stalls and occasional resets
        for (int i = 0; i < 400; i++) begin
            applyStimulus($urandom_range(0, 1) == 1, rand128(), $urandom_range(0, 1) == 1,
                          $urandom_range(0, 3) != 0, $urandom_range(0, 40) != 0);
            tick();
        end
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1'b0, rand128(), 1'b0, 1'b1, 1'b1);
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
